// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture path: FSM encoding, RGB565 layout
// and default frame geometry used by the capture block and the framebuffer.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_CFG = 2'd0,
    ST_WAIT_VS  = 2'd1,
    ST_SKIP     = 2'd2,
    ST_CAPTURE  = 2'd3
  } cap_state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  function automatic logic [15:0] rgb565_pack(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera-side inputs and pixel-stream outputs of the capture block.
// pixel_valid is a one-cycle strobe with no backpressure: pixel, x, y and
// wr_addr are meaningful only while it is high, and the consumer must take
// every strobe. frame_start/frame_done are single-cycle pulses.
interface ov7670_capture_if #(
  parameter int ADDR_W = 19
);
  import ov7670_capture_pkg::*;

  logic              config_done;
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [15:0]       pixel;
  logic              pixel_valid;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_start;
  logic              frame_done;
  logic              line_err;
  logic              frame_err;
  cap_state_t        dbg_state;

  modport master (
    input  config_done, vsync, href, d,
    output pixel, pixel_valid, x, y, wr_addr,
    output frame_start, frame_done, line_err, frame_err, dbg_state
  );

  modport slave (
    output config_done, vsync, href, d,
    input  pixel, pixel_valid, x, y, wr_addr,
    input  frame_start, frame_done, line_err, frame_err, dbg_state
  );

endinterface

// File: rtl/ov7670_capture_sync_edges.sv
// Input register for the camera bus plus one extra stage for vsync/href edge
// detection; edges are aligned with the registered copies.
module ov7670_capture_sync_edges (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_d,
  output logic       o_href_q,
  output logic [7:0] o_d_q,
  output logic       o_vsync_rise,
  output logic       o_vsync_fall,
  output logic       o_href_fall
);

  logic       r_vsync_q;
  logic       r_vsync_qq;
  logic       r_href_q;
  logic       r_href_qq;
  logic [7:0] r_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q  <= 1'b0;
      r_vsync_qq <= 1'b0;
      r_href_q   <= 1'b0;
      r_href_qq  <= 1'b0;
      r_d_q      <= 8'd0;
    end else begin
      r_vsync_q  <= i_vsync;
      r_vsync_qq <= r_vsync_q;
      r_href_q   <= i_href;
      r_href_qq  <= r_href_q;
      r_d_q      <= i_d;
    end
  end

  assign o_href_q     = r_href_q;
  assign o_d_q        = r_d_q;
  assign o_vsync_rise = r_vsync_q & ~r_vsync_qq;
  assign o_vsync_fall = ~r_vsync_q & r_vsync_qq;
  assign o_href_fall  = ~r_href_q & r_href_qq;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: waits for configuration, discards unstable frames,
// then assembles byte pairs into pixels with coordinates and linear address.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int SKIP_FRAMES = 2,
  parameter int ADDR_W      = 19
) (
  input  logic             clk,
  input  logic             rst,
  ov7670_capture_if.master cam
);

  localparam logic [9:0]  X_LIM       = 10'(WIDTH);
  localparam logic [8:0]  Y_LIM       = 9'(HEIGHT);
  localparam logic [10:0] LINE_BYTES  = 11'(2 * WIDTH);
  localparam logic [9:0]  LINE_TARGET = 10'(HEIGHT);
  localparam logic [7:0]  SKIP_TARGET = 8'(SKIP_FRAMES);

  logic       w_href_q;
  logic [7:0] w_d_q;
  logic       w_vsync_rise;
  logic       w_vsync_fall;
  logic       w_href_fall;

  ov7670_capture_sync_edges u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_vsync      (cam.vsync),
    .i_href       (cam.href),
    .i_d          (cam.d),
    .o_href_q     (w_href_q),
    .o_d_q        (w_d_q),
    .o_vsync_rise (w_vsync_rise),
    .o_vsync_fall (w_vsync_fall),
    .o_href_fall  (w_href_fall)
  );

  cap_state_t        r_state;
  logic [7:0]        r_skip_cnt;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [10:0]       r_byte_cnt;
  logic [9:0]        r_line_cnt;
  logic [15:0]       r_pixel;
  logic              r_pixel_valid;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_start;
  logic              r_frame_done;
  logic              r_line_err;
  logic              r_frame_err;

  logic [10:0] w_byte_cnt_inc;
  logic [9:0]  w_line_cnt_inc;
  logic [9:0]  w_lines_final;
  logic        w_emit_ok;

  assign w_byte_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_line_cnt_inc = (r_line_cnt == 10'h3FF) ? r_line_cnt : r_line_cnt + 10'd1;
  // A line ending in the same cycle as vsync rising still counts toward the frame.
  assign w_lines_final  = w_href_fall ? w_line_cnt_inc : r_line_cnt;
  assign w_emit_ok      = (r_x < X_LIM) && (r_y < Y_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_WAIT_CFG;
      r_skip_cnt    <= 8'd0;
      r_phase       <= 1'b0;
      r_hi          <= 8'd0;
      r_byte_cnt    <= 11'd0;
      r_line_cnt    <= 10'd0;
      r_pixel       <= 16'd0;
      r_pixel_valid <= 1'b0;
      r_x           <= 10'd0;
      r_y           <= 9'd0;
      r_wr_addr     <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (!cam.config_done && (r_state != ST_WAIT_CFG)) begin
        r_state     <= ST_WAIT_CFG;
        r_skip_cnt  <= 8'd0;
        r_phase     <= 1'b0;
        r_line_err  <= 1'b0;
        r_frame_err <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_CFG: begin
            if (cam.config_done) r_state <= ST_WAIT_VS;
          end
          ST_WAIT_VS: begin
            if (w_vsync_fall) begin
              if (r_skip_cnt < SKIP_TARGET) begin
                r_skip_cnt <= r_skip_cnt + 8'd1;
                r_state    <= ST_SKIP;
              end else begin
                r_state    <= ST_CAPTURE;
                r_x        <= 10'd0;
                r_y        <= 9'd0;
                r_wr_addr  <= '0;
                r_line_cnt <= 10'd0;
                r_byte_cnt <= 11'd0;
                r_phase    <= 1'b0;
              end
            end
          end
          ST_SKIP: begin
            if (w_vsync_rise) r_state <= ST_WAIT_VS;
          end
          ST_CAPTURE: begin
            if (w_href_q) begin
              r_phase    <= ~r_phase;
              r_byte_cnt <= w_byte_cnt_inc;
              if (!r_phase) begin
                r_hi <= w_d_q;
              end else if (w_emit_ok) begin
                r_pixel       <= {r_hi, w_d_q};
                r_pixel_valid <= 1'b1;
                r_frame_start <= (r_x == 10'd0) && (r_y == 9'd0);
              end
            end else begin
              r_phase <= 1'b0;
            end
            // Coordinates advance the cycle after the strobe so outputs match the pixel.
            if (r_pixel_valid) begin
              r_x       <= r_x + 10'd1;
              r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (w_href_fall) begin
              r_x        <= 10'd0;
              r_line_cnt <= w_line_cnt_inc;
              r_byte_cnt <= 11'd0;
              if (r_y < Y_LIM) r_y <= r_y + 9'd1;
              if (r_byte_cnt != LINE_BYTES) r_line_err <= 1'b1;
            end
            if (w_vsync_rise) begin
              if (w_lines_final == LINE_TARGET) r_frame_done <= 1'b1;
              else r_frame_err <= 1'b1;
              r_state <= ST_WAIT_VS;
            end
          end
          default: r_state <= ST_WAIT_CFG;
        endcase
      end
    end
  end

  assign cam.pixel       = r_pixel;
  assign cam.pixel_valid = r_pixel_valid;
  assign cam.x           = r_x;
  assign cam.y           = r_y;
  assign cam.wr_addr     = r_wr_addr;
  assign cam.frame_start = r_frame_start;
  assign cam.frame_done  = r_frame_done;
  assign cam.line_err    = r_line_err;
  assign cam.frame_err   = r_frame_err;
  assign cam.dbg_state   = r_state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 4x2 frame with two skipped frames;
// every expected pixel (value, coordinates, address, strobe cycle) is queued.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int SKIP   = 2;
  localparam int ADDR_W = 19;
  localparam int EW     = 75;

  logic clk;
  logic rst;
  logic [19:0] cyc = '0;
  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int m_x, m_y, m_addr;
  logic [EW-1:0] exp_q[$];

  ov7670_capture_if #(.ADDR_W(ADDR_W)) cam();

  ov7670_capture #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SKIP_FRAMES(SKIP), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 20'd1;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on each strobe
  always @(negedge clk) begin
    if (cam.pixel_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pixel observed=%0h x=%0d y=%0d expected=none", cam.pixel, cam.x, cam.y);
      end
      if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("pix_value", 64'(cam.pixel), 64'(e[73:58]));
        check("pix_x", 64'(cam.x), 64'(e[57:48]));
        check("pix_y", 64'(cam.y), 64'(e[47:39]));
        check("pix_addr", 64'(cam.wr_addr), 64'(e[38:20]));
        check("pix_frame_start", 64'(cam.frame_start), 64'(e[74]));
        check("pix_cycle", 64'(cyc), 64'(e[19:0]));
      end
    end
    if (cam.frame_start) check("frame_start_has_valid", 64'(cam.pixel_valid), 64'd1);
    if (cam.frame_done) fd_cnt++;
  end

  // driver tasks
  task automatic partial_line(input int nb, input bit cap, input bit fixed, input logic [15:0] p0);
    logic [7:0] b;
    logic [7:0] hi;
    hi = 8'd0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (fixed && i == 0) b = p0[15:8];
      else if (fixed && i == 1) b = p0[7:0];
      else b = 8'($urandom_range(0, 255));
      cam.href = 1'b1;
      cam.d    = b;
      if (i % 2 == 0) begin
        hi = b;
      end else if (cap && m_x < WIDTH && m_y < HEIGHT) begin
        exp_q.push_back({(m_x == 0 && m_y == 0), hi, b, 10'(m_x), 9'(m_y), 19'(m_addr), cyc + 20'd2});
        m_x++;
        m_addr++;
      end
    end
  endtask

  task automatic end_line(input bit cap);
    @(negedge clk);
    cam.href = 1'b0;
    repeat (3) @(negedge clk);
    if (cap) begin
      m_x = 0;
      if (m_y < HEIGHT) m_y++;
    end
  endtask

  task automatic send_line(input int nb, input bit cap, input bit fixed, input logic [15:0] p0);
    partial_line(nb, cap, fixed, p0);
    end_line(cap);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    cam.vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam.vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input bit cap, input int nl, input int b0, input bit fixed, input logic [15:0] p0);
    if (cap) begin
      m_x = 0; m_y = 0; m_addr = 0;
    end
    for (int l = 0; l < nl; l++)
      send_line((l == 0) ? b0 : 2 * WIDTH, cap, fixed && (l == 0), p0);
  endtask

  task automatic skip_then_capture(input int b0, input bit fixed);
    vs_pulse(); frame(1'b0, HEIGHT, 2 * WIDTH, 1'b0, 16'h0);
    vs_pulse(); frame(1'b0, HEIGHT, 2 * WIDTH, 1'b0, 16'h0);
    vs_pulse(); frame(1'b1, HEIGHT, b0, fixed, rgb565_pack(5'h1F, 6'h00, 5'h1F));
    vs_pulse();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pixel"}, 64'(cam.pixel), 64'd0);
    check({tag, "_valid"}, 64'(cam.pixel_valid), 64'd0);
    check({tag, "_x"}, 64'(cam.x), 64'd0);
    check({tag, "_y"}, 64'(cam.y), 64'd0);
    check({tag, "_addr"}, 64'(cam.wr_addr), 64'd0);
    check({tag, "_fstart"}, 64'(cam.frame_start), 64'd0);
    check({tag, "_fdone"}, 64'(cam.frame_done), 64'd0);
    check({tag, "_line_err"}, 64'(cam.line_err), 64'd0);
    check({tag, "_frame_err"}, 64'(cam.frame_err), 64'd0);
    check({tag, "_state"}, 64'(cam.dbg_state), 64'(ST_WAIT_CFG));
  endtask

  // directed sequence
  initial begin
    rst = 1'b1;
    cam.config_done = 1'b0;
    cam.vsync = 1'b0;
    cam.href  = 1'b0;
    cam.d     = 8'd0;
    m_x = 0; m_y = 0; m_addr = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // unconfigured: a whole frame must produce nothing
    vs_pulse(); frame(1'b0, HEIGHT, 2 * WIDTH, 1'b0, 16'h0); vs_pulse();
    check("unconfigured_state", 64'(cam.dbg_state), 64'(ST_WAIT_CFG));

    // skip two frames, capture third; first pixel is 0xF81F
    @(negedge clk); cam.config_done = 1'b1;
    skip_then_capture(2 * WIDTH, 1'b1);
    check("cap1_frame_done", 64'(fd_cnt), 64'd1);
    check("cap1_line_err", 64'(cam.line_err), 64'd0);
    check("cap1_frame_err", 64'(cam.frame_err), 64'd0);
    check("cap1_queue_empty", 64'(exp_q.size()), 64'd0);

    // short first line: 3 pixels, sticky line_err, frame still complete
    frame(1'b1, HEIGHT, 6, 1'b0, 16'h0); vs_pulse();
    check("short_line_frame_done", 64'(fd_cnt), 64'd2);
    check("short_line_line_err", 64'(cam.line_err), 64'd1);
    check("short_line_frame_err", 64'(cam.frame_err), 64'd0);
    check("short_line_queue_empty", 64'(exp_q.size()), 64'd0);

    // short frame with an overlong line: extra pixel dropped, frame_err, no frame_done
    frame(1'b1, 1, 10, 1'b0, 16'h0); vs_pulse();
    check("short_frame_frame_done", 64'(fd_cnt), 64'd2);
    check("short_frame_frame_err", 64'(cam.frame_err), 64'd1);
    check("short_frame_queue_empty", 64'(exp_q.size()), 64'd0);
    frame(1'b1, HEIGHT, 2 * WIDTH, 1'b0, 16'h0); vs_pulse();
    check("recover_frame_done", 64'(fd_cnt), 64'd3);
    check("recover_frame_err_sticky", 64'(cam.frame_err), 64'd1);

    // reset mid-line during capture
    m_x = 0; m_y = 0; m_addr = 0;
    partial_line(3, 1'b1, 1'b0, 16'h0);
    @(negedge clk); rst = 1'b1; cam.href = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    @(negedge clk); rst = 1'b0;
    check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);

    // skip sequence repeats; captured frame has an odd-length first line
    skip_then_capture(7, 1'b0);
    check("odd_frame_done", 64'(fd_cnt), 64'd4);
    check("odd_line_err", 64'(cam.line_err), 64'd1);
    check("odd_frame_err", 64'(cam.frame_err), 64'd0);
    check("odd_queue_empty", 64'(exp_q.size()), 64'd0);

    // configuration drops mid-line
    m_x = 0; m_y = 0; m_addr = 0;
    partial_line(3, 1'b1, 1'b0, 16'h0);
    @(negedge clk); cam.config_done = 1'b0;
    partial_line(5, 1'b0, 1'b0, 16'h0);
    end_line(1'b0);
    check("drop_state", 64'(cam.dbg_state), 64'(ST_WAIT_CFG));
    check("drop_line_err_cleared", 64'(cam.line_err), 64'd0);
    send_line(2 * WIDTH, 1'b0, 1'b0, 16'h0);
    vs_pulse();
    check("drop_no_frame_done", 64'(fd_cnt), 64'd4);
    check("drop_queue_empty", 64'(exp_q.size()), 64'd0);

    // re-assertion: skip counter was cleared, so two frames are discarded again
    @(negedge clk); cam.config_done = 1'b1;
    skip_then_capture(2 * WIDTH, 1'b0);
    check("reconf_frame_done", 64'(fd_cnt), 64'd5);
    check("reconf_queue_empty", 64'(exp_q.size()), 64'd0);
    check("reconf_state", 64'(cam.dbg_state), 64'(ST_CAPTURE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream of the camera configuration stage. Once SCCB configuration reports done, this block captures the OV7670 parallel pixel bus (RGB565, two bytes per pixel).
- Emits one 16-bit pixel per valid strobe, with x/y coordinates and a linear frame-buffer write address.
- Discards the first frames after configuration, which are unstable, and flags malformed lines and frames.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- SKIP_FRAMES, 2, complete frames discarded after config_done rises (0 = capture first full frame).
- ADDR_W, 19, width of wr_addr; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  camera PCLK; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- config_done  in  1  level from configuration stage; already synchronised to clk.
- vsync  in  1  camera VSYNC, active high during vertical blanking.
- href  in  1  camera HREF, high while line bytes are valid.
- d  in  8  camera data byte.
- pixel  out  16  RGB565, {first byte, second byte}.
- pixel_valid  out  1  one-cycle strobe per assembled pixel.
- x  out  10  column of current pixel, 0..WIDTH-1.
- y  out  9  row of current pixel, 0..HEIGHT-1.
- wr_addr  out  ADDR_W  y*WIDTH+x, maintained incrementally (no multiplier).
- frame_start  out  1  one-cycle pulse on first pixel of a captured frame.
- frame_done  out  1  one-cycle pulse after the last line of a captured frame completes.
- line_err  out  1  sticky; set when a line ends with byte count != 2*WIDTH.
- frame_err  out  1  sticky; set when vsync rises with line count != HEIGHT.

Behaviour:
- Input register: vsync, href and d sampled into vsync_q, href_q and d_q every edge. All logic uses the _q copies.
- Edge detection uses one more stage: vsync_rise, vsync_fall, href_fall.
- Reset values:
  - pixel=0, pixel_valid=0, x=0, y=0, wr_addr=0.
  - frame_start=0, frame_done=0, line_err=0, frame_err=0.
  - state=WAIT_CFG, skip counter=0, byte phase=0.
- FSM states:
  - WAIT_CFG: stay while config_done=0. On config_done=1, go to WAIT_VS.
  - WAIT_VS: wait for vsync_fall.
    - If skip counter < SKIP_FRAMES, go to SKIP and increment the counter.
    - Otherwise go to CAPTURE.
  - SKIP: ignore data. On vsync_rise, go back to WAIT_VS.
  - CAPTURE: assemble pixels. On vsync_rise, pulse frame_done (if lines == HEIGHT), set frame_err if lines != HEIGHT, then go to WAIT_VS. The skip counter is saturated, so every later frame is captured.
  - config_done falling in any state: go to WAIT_CFG and clear the skip counter. No pulses are emitted.
- Byte assembly (CAPTURE, href_q=1):
  - phase 0: latch d_q as high byte.
  - phase 1: pixel <= {hi, d_q}, pixel_valid <= 1 on the next edge.
  - Phase toggles every href_q cycle and is cleared whenever href_q=0.
  - Latency: pixel_valid is high on the edge after the second byte is in d_q, i.e. 2 clk after the second byte is on the pins.
- Coordinates:
  - x increments after each pixel_valid.
  - On href_fall: x<=0, y<=y+1, and line_err is set if bytes != 2*WIDTH.
  - Pixels with x >= WIDTH or y >= HEIGHT are dropped: no pixel_valid, coordinates saturate.
  - wr_addr increments with each emitted pixel and resets to 0 at frame start.
  - x, y and wr_addr are cleared on entry to CAPTURE.
- frame_start: pulses with the first pixel_valid of CAPTURE (x=0, y=0), in the same cycle.
- Odd byte count: a trailing half pixel at href_fall is discarded and line_err is set.
- Simultaneous events: a vsync_rise in the same cycle as href_fall still increments the line count first, then evaluates frame_err.
- rst mid-frame: all outputs return to reset values on the next edge. After reset the block waits for config_done, then SKIP_FRAMES full frames, before capturing.
- Error flags: line_err and frame_err clear only on rst or on WAIT_CFG entry.

Decomposition:
- Shared package (cam_pkg): RGB565 field positions, the FSM state encoding (WAIT_CFG, WAIT_VS, SKIP, CAPTURE), and default WIDTH/HEIGHT constants shared with the framebuffer.
- One natural sub-module: cam_sync_edges, covering the input register and the vsync/href edge-detect pipeline. All other logic stays flat.

Test Plan:
- Skip frames: config_done=0, then 1, with SKIP_FRAMES=2 and WIDTH=4, HEIGHT=2 -> no pixel_valid for the first 2 frames. On the third frame, 8 strobes with x=0..3, y=0..1, wr_addr=0..7.
- Byte pairing: bytes 0xF8,0x1F -> pixel=0xF81F, pixel_valid 2 clk after 0x1F driven. First pixel coincides with frame_start.
- Short line: line with 6 bytes (WIDTH=4) -> 3 pixels, line_err=1 (sticky). Next line restarts at x=0.
- Short frame: vsync_rise after 1 line (HEIGHT=2) -> frame_err=1, no frame_done. Next well-formed frame still produces frame_done.
- Reset mid-capture: rst asserted mid-line in CAPTURE -> next edge all outputs 0, state WAIT_CFG. SKIP_FRAMES frames are discarded again.
- Config drop: config_done deasserts mid-frame -> pixel_valid stops immediately and the skip counter clears. Re-assertion repeats the skip sequence.
